// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM state encoding
//   INSTR_NOP     : canonical RV32I NOP (addi x0, x0, 0)
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory request/response channel.
//   req_valid / req_ready / addr : read request handshake (fetch -> memory)
//   rsp_valid / rsp_data         : read response (memory -> fetch)
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage behind the program counter: latches pc on an accepted
// fetch_start, issues one instruction-memory read, and holds the returned
// word for decode until decode takes it. A flush abandons any in-flight
// fetch; a request already accepted by memory is drained in DROP so its
// stale response never reaches decode.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   pc, fetch_start   fetch request from the program counter
//   flush             redirect (branch / JAL / JALR)
//   busy              fetch_start is ignored while high
//   imem              instruction-memory channel (master modport)
//   instr_valid/ready decode handshake; instr, instr_pc are the held word
//   fetch_fault       one-cycle pulse on a misaligned pc
//
// Build option: define FETCH_ALIGN_CHECK_EN to reject misaligned pcs with
// a fetch_fault pulse instead of fetching the word-aligned address.
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                fetch_start,
    input  logic                flush,
    output logic                busy,
    instr_fetch_unit_if.master  imem,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [DATA_W-1:0]   instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                fetch_fault
);

    fetch_state_t      state_r;
    fetch_state_t      state_nxt_s;
    logic [ADDR_W-1:0] pc_lat_r;
    logic [DATA_W-1:0] instr_r;
    logic [ADDR_W-1:0] instr_pc_r;
    logic              busy_r;
    logic              req_valid_r;
    logic              instr_valid_r;
    logic              fetch_fault_r;
    logic              misalign_s;
    logic              load_pc_s;
    logic              load_instr_s;
    logic              fault_s;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_s = (pc[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state and datapath-load decode; flush outranks every other input.
    always_comb begin
        state_nxt_s  = state_r;
        load_pc_s    = 1'b0;
        load_instr_s = 1'b0;
        fault_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (fetch_start) begin
                    if (misalign_s) begin
                        fault_s = 1'b1;
                    end else begin
                        load_pc_s   = 1'b1;
                        state_nxt_s = REQ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (flush) begin
                    // A request memory has already taken must still be drained.
                    state_nxt_s = imem.req_ready ? DROP : IDLE;
                end else if (imem.req_ready) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt_s = imem.rsp_valid ? IDLE : DROP;
                end else if (imem.rsp_valid) begin
                    load_instr_s = 1'b1;
                    state_nxt_s  = HOLD;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (instr_ready) begin
                    // Back-to-back fetch: accept the next pc in the handoff cycle.
                    if (fetch_start && !misalign_s) begin
                        load_pc_s   = 1'b1;
                        state_nxt_s = REQ;
                    end else begin
                        fault_s     = fetch_start;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            DROP: begin
                if (imem.rsp_valid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, address/instruction registers and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            pc_lat_r      <= {ADDR_W{1'b0}};
            instr_r       <= {DATA_W{1'b0}};
            instr_pc_r    <= {ADDR_W{1'b0}};
            busy_r        <= 1'b0;
            req_valid_r   <= 1'b0;
            instr_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (load_pc_s) begin
                pc_lat_r <= pc;
            end
            if (load_instr_s) begin
                instr_r    <= imem.rsp_data;
                instr_pc_r <= pc_lat_r;
            end
            busy_r        <= (state_nxt_s == REQ) || (state_nxt_s == WAIT) ||
                             (state_nxt_s == DROP);
            req_valid_r   <= (state_nxt_s == REQ);
            instr_valid_r <= (state_nxt_s == HOLD);
            fetch_fault_r <= fault_s;
        end
    end

    assign busy           = busy_r;
    assign imem.req_valid = req_valid_r;
    assign imem.addr      = {pc_lat_r[ADDR_W-1:2], 2'b00};
    assign instr_valid    = instr_valid_r;
    assign instr          = instr_r;
    assign instr_pc       = instr_pc_r;
    assign fetch_fault    = fetch_fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed scenarios followed by randomized traffic. A memory responder with
// variable latency serves the DUT; a transaction-level reference model tracks
// the life of each fetch (requested, accepted by memory, delivered, discarded)
// and predicts the DUT outputs after every clock edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc;
    logic        fetch_start;
    logic        flush;
    logic        busy;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    // memory responder state
    bit          mem_owed = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_dly = 0;
    int          mem_delay_next = 0;
    bit          mem_rsp_always = 1'b1;

    // reference model: life of the current fetch
    bit          m_want = 1'b0;      // a fetch destined for decode exists
    bit          m_taken = 1'b0;     // memory has accepted its request
    bit          m_got = 1'b0;       // its word is being offered to decode
    bit          m_discard = 1'b0;   // a flushed request still owes a response
    bit          m_fault = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_data = 32'h0;

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .fetch_start (fetch_start),
        .flush       (flush),
        .busy        (busy),
        .imem        (bus.master),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100)      return 32'h0050_0093;
        else if (a == 32'h0000_0200) return INSTR_NOP;
        else                         return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("busy", {31'b0, busy}, {31'b0, (m_want && !m_got) || m_discard});
        check_eq("req_valid", {31'b0, bus.req_valid}, {31'b0, m_want && !m_taken && !m_got});
        check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_got});
        check_eq("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        if (m_want && !m_taken && !m_got) check_eq("imem_addr", bus.addr, m_pc & 32'hFFFF_FFFC);
        if (m_got) begin
            check_eq("instr", instr, m_data);
            check_eq("instr_pc", instr_pc, m_pc);
        end
    endtask

    task automatic model_start(input logic [31:0] p);
`ifdef FETCH_ALIGN_CHECK_EN
        if (p[1:0] != 2'b00) begin
            m_fault = 1'b1;
            return;
        end
`endif
        m_want  = 1'b1;
        m_taken = 1'b0;
        m_got   = 1'b0;
        m_pc    = p;
    endtask

    // One clock: drive inputs at the falling edge, predict, check after the rising edge.
    task automatic cycle(input logic fs, input logic [31:0] p, input logic fl,
                         input logic ir, input logic rr);
        logic rv;
        logic hs_req;
        bit   free;
        fetch_start   = fs;
        pc            = p;
        flush         = fl;
        instr_ready   = ir;
        bus.req_ready = rr;
        rv = mem_owed && (mem_dly == 0) && (mem_rsp_always || ($urandom_range(0, 3) != 0));
        bus.rsp_valid = rv;
        bus.rsp_data  = rv ? mem_word(mem_addr) : $urandom;
        hs_req = bus.req_valid && rr;
        if (rv) mem_owed = 1'b0;
        else if (mem_owed && mem_dly > 0) mem_dly--;
        if (hs_req) begin
            check_eq("single_outstanding", {31'b0, mem_owed}, 32'h0);
            mem_owed = 1'b1;
            mem_addr = bus.addr;
            mem_dly  = (mem_delay_next < 0) ? $urandom_range(0, 2) : mem_delay_next;
        end
        m_fault = 1'b0;
        if (m_discard) begin
            if (rv) m_discard = 1'b0;
        end else if (m_want && !m_taken && !m_got) begin
            if (fl) begin
                m_want    = 1'b0;
                m_discard = rr;
            end else if (rr) begin
                m_taken = 1'b1;
            end
        end else if (m_want && m_taken && !m_got) begin
            if (fl) begin
                m_want    = 1'b0;
                m_taken   = 1'b0;
                m_discard = !rv;
            end else if (rv) begin
                m_got  = 1'b1;
                m_data = mem_word(m_pc & 32'hFFFF_FFFC);
            end
        end else begin
            free = !m_got || (ir && !fl);
            if (m_got && (fl || ir)) begin
                m_got   = 1'b0;
                m_want  = 1'b0;
                m_taken = 1'b0;
            end
            if (free && fs) model_start(p);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        reset_n       = 1'b0;
        pc            = 32'h0;
        fetch_start   = 1'b0;
        flush         = 1'b0;
        instr_ready   = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = 32'h0;
        #12;
        check_eq("rst_busy", {31'b0, busy}, 32'h0);
        check_eq("rst_req_valid", {31'b0, bus.req_valid}, 32'h0);
        check_eq("rst_addr", bus.addr, 32'h0);
        check_eq("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_fault", {31'b0, fetch_fault}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: fetch 0x100, memory ready at once, response one cycle later
        mem_delay_next = 0;
        mem_rsp_always = 1'b1;
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        check_eq("t1_req_c1", {31'b0, bus.req_valid}, 32'h1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("t1_novalid_c2", {31'b0, instr_valid}, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("t1_valid_c3", {31'b0, instr_valid}, 32'h1);
        check_eq("t1_instr", instr, 32'h0050_0093);
        check_eq("t1_instr_pc", instr_pc, 32'h100);

        // 2: decode stalls five cycles, then takes it while starting 0x104
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("t2_stable", instr, 32'h0050_0093);
        cycle(1'b1, 32'h104, 1'b0, 1'b1, 1'b0);
        check_eq("t2_req", {31'b0, bus.req_valid}, 32'h1);
        check_eq("t2_addr", bus.addr, 32'h104);

        // 3: memory not ready for three cycles, extra fetch_start ignored
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        check_eq("t3_addr", bus.addr, 32'h104);
        check_eq("t3_busy", {31'b0, busy}, 32'h1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // 4: flush while waiting; the response two cycles later is dropped
        mem_delay_next = 2;
        cycle(1'b1, 32'h180, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check_eq("t4_drop_busy", {31'b0, busy}, 32'h1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_eq("t4_no_instr", {31'b0, instr_valid}, 32'h0);
        mem_delay_next = 0;
        cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("t4_instr", instr, 32'h0000_0013);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // 5: reset asserted while waiting for the response
        mem_delay_next = 3;
        cycle(1'b1, 32'h240, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_busy", {31'b0, busy}, 32'h0);
        check_eq("t5_req_valid", {31'b0, bus.req_valid}, 32'h0);
        check_eq("t5_addr", bus.addr, 32'h0);
        check_eq("t5_instr", instr, 32'h0);
        m_want = 1'b0; m_taken = 1'b0; m_got = 1'b0; m_discard = 1'b0;
        m_fault = 1'b0; mem_owed = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // 6: misaligned pc
        mem_delay_next = 0;
        cycle(1'b1, 32'h102, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("t6_fault", {31'b0, fetch_fault}, 32'h1);
        check_eq("t6_no_req", {31'b0, bus.req_valid}, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_fault_pulse", {31'b0, fetch_fault}, 32'h0);
`else
        check_eq("t6_addr", bus.addr, 32'h100);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
`endif

        // randomized traffic
        mem_delay_next = -1;
        mem_rsp_always = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic        fs;
            logic        fl;
            logic [31:0] p;
            fs = ($urandom_range(0, 1) == 1);
            fl = !fs && ($urandom_range(0, 9) == 0);
            p  = 32'h1000 + ($urandom_range(0, 255) << 2);
            cycle(fs, p, fl, $urandom_range(0, 4) < 3, $urandom_range(0, 4) < 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
